serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new operation.
REQ-005 SHALL have port: sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port: a  input  WIDTH  operand A; sampled with start.
REQ-007 SHALL have port: b  input  WIDTH  operand B; sampled with start.
REQ-008 SHALL have port: busy  output  1  high while in RUN.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, results valid.
REQ-010 SHALL have port: z  output  WIDTH  sum/difference.
REQ-011 SHALL have port: cout  output  1  final carry out of MSB.
REQ-012 SHALL have port: ovf  output  1  two's-complement overflow.

Function
REQ-013 SHALL compute with exactly one 1-bit full-adder cell (a, b, cin -> z, cout), time-multiplexed one bit per cycle, LSB first; no wider adder.
REQ-014 SHALL implement states IDLE, RUN, DONE; encoding is free.
REQ-015 In IDLE, start=1 SHALL be accepted: latch a, latch b (or ~b if sub=1), carry <= sub, bit index <= 0, next state RUN.
REQ-016 In IDLE, start=0 SHALL hold state.
REQ-017 In RUN, each cycle SHALL feed latched bits [index] and carry to the cell, store cell sum into internal result bit [index], carry <= cell carry-out, index <= index+1.
REQ-018 RUN SHALL last exactly WIDTH cycles, then enter DONE after the cycle processing index WIDTH-1.
REQ-019 DONE SHALL last exactly one cycle with done=1, then enter IDLE unconditionally.
REQ-020 start SHALL be ignored in RUN and DONE; changes on a, b, sub after acceptance SHALL have no effect.
REQ-021 Latency: start accepted in cycle T -> busy=1 in cycles T+1..T+WIDTH -> done=1 in cycle T+WIDTH+1 only.
REQ-022 Back-to-back: start held high SHALL give one accepted operation every WIDTH+2 cycles.
REQ-023 z, cout, ovf SHALL update only on the edge entering DONE and hold until the next DONE entry.
REQ-024 cout SHALL be the carry out of bit WIDTH-1 (for sub: 1 = no borrow).
REQ-025 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-026 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; both registered or pure state decodes, glitch-free at cycle level.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-028 reset=1 at a rising edge SHALL force state IDLE, index 0, carry 0, z 0, cout 0, ovf 0, busy 0, done 0, with priority over all other inputs.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no done pulse; the next start after reset deasserts SHALL be accepted normally.
REQ-030 start sampled in the same cycle as reset=1 SHALL be dropped.

Verification
REQ-031 Reset, then WIDTH=32, a=5, b=3, sub=0, start for 1 cycle at T -> busy T+1..T+32, done at T+33 only, z=8, cout=0, ovf=0.
REQ-032 a=0xFFFFFFFF, b=1, add -> z=0x00000000, cout=1, ovf=0; a=0x7FFFFFFF, b=1, add -> z=0x80000000, cout=0, ovf=1.
REQ-033 sub: a=5, b=3 -> z=2, cout=1, ovf=0; a=3, b=5 -> z=0xFFFFFFFE, cout=0, ovf=0; a=0x80000000, b=1 -> z=0x7FFFFFFF, ovf=1.
REQ-034 During RUN, pulse start and change a, b, sub -> ignored; result matches originally latched operands; z/cout/ovf unchanged until DONE.
REQ-035 Assert reset at RUN cycle 10 -> next cycle busy=0, done never pulses, z=0, cout=0, ovf=0; new start then completes correctly.
REQ-036 Hold start=1 continuously with changing operands -> done every 34 cycles, each result matching operands present at its accepting IDLE cycle.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, WIDTH cycles per operation.
// Operation sequence: IDLE accepts start, RUN processes one bit per cycle, DONE pulses done for one cycle.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_c;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             sum_c;
  logic             cy_c;
  logic             last_c;

  // The single full-adder cell plus the partial result that includes this cycle's sum bit.
  always_comb begin
    sum_c      = a_r[idx] ^ b_r[idx] ^ carry;
    cy_c       = (a_r[idx] & b_r[idx]) | (a_r[idx] & carry) | (b_r[idx] & carry);
    last_c     = (idx == IW'(WIDTH - 1));
    res_c      = res;
    res_c[idx] = sum_c;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_c) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      z     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          res   <= res_c;
          carry <= cy_c;
          idx   <= idx + IW'(1);
          // Overflow compares the carry into the MSB with the carry out of it.
          if (last_c) begin
            z    <= res_c;
            cout <= cy_c;
            ovf  <= carry ^ cy_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: cycle-level behavioural model plus directed and random stimulus.
module tb_serial_adder_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          sub;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  z;
  logic          cout;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .z(z), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_cnt = 0 idle, 1..W busy cycles, W+1 the done cycle.
  int           m_cnt = 0;
  logic [W-1:0] m_z = '0, p_z = '0;
  logic         m_c = 1'b0, m_o = 1'b0, p_c = 1'b0, p_o = 1'b0;
  bit           chk_en = 1'b0;
  int           cyc = 0;

  always @(posedge clk) begin
    logic [W:0] full;
    cyc++;
    if (reset) begin
      m_cnt = 0; m_z = '0; m_c = 1'b0; m_o = 1'b0; chk_en = 1'b1;
    end else if (m_cnt == 0) begin
      if (start) begin
        if (sub) full = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     full = {1'b0, a} + {1'b0, b};
        p_z = full[W-1:0];
        p_c = full[W];
        if (sub) p_o = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        else     p_o = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        m_cnt = 1;
      end
    end else if (m_cnt == W + 1) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == W + 1) begin
        m_z = p_z; m_c = p_c; m_o = p_o;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_cnt >= 1 && m_cnt <= W));
      chk("done", 32'(done), 32'(m_cnt == W + 1));
      chk("z",    z,         m_z);
      chk("cout", 32'(cout), 32'(m_c));
      chk("ovf",  32'(ovf),  32'(m_o));
    end
  end

  // One operation from IDLE; optionally scramble inputs while running. Checks latency and literal results.
  task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                    input logic [W-1:0] ez, input logic ec, input logic eo, input bit scramble);
    int n;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; sub = sv;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", 32'(n), 32'(W + 1));
    chk("lit_z", z, ez);
    chk("lit_cout", 32'(cout), 32'(ec));
    chk("lit_ovf", 32'(ovf), 32'(eo));
    chk("model_z", m_z, ez);
  endtask

  initial begin
    int last_done;
    int ndone;
    reset = 1'b1; start = 1'b1; sub = 1'b0; a = '1; b = '1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_z", z, 32'd0);
    reset = 1'b0; start = 1'b0;

    op(32'd5, 32'd3, 1'b0, 32'd8, 1'b0, 1'b0, 1'b0);
    op(32'hFFFFFFFF, 32'd1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    op(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    op(32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0);
    op(32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    op(32'h80000000, 32'd1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b1);
    op(32'h12345678, 32'h0F0F0F0F, 1'b0, 32'h21436587, 1'b0, 1'b0, 1'b1);

    // Abort in the tenth RUN cycle.
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd200; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_z", z, 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    op(32'd7, 32'd9, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);

    // Start held high with operands changing every cycle.
    last_done = -1; ndone = 0;
    start = 1'b1;
    for (int i = 0; i < 6 * (W + 2); i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) begin
        if (last_done >= 0) chk("b2b_period", 32'(cyc - last_done), 32'(W + 2));
        last_done = cyc;
        ndone++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(ndone >= 5), 32'd1);
    repeat (W + 4) @(negedge clk);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
        b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1;
      end
      @(negedge clk);
    end
    reset = 1'b0; start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
